// File: rtl/cpu_pkg.sv
// Shared core constants and the register-file
// dump engine state encoding.
package cpu_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file debug dump engine: walks an
// address range and streams (addr, value) pairs.
module regfile_dump
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  dump_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;

  // Next-state, address walk and capture logic;
  // status flags are decoded from the next state
  // so every output leaves a flop.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          state_d    = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_data_d = rf_data;
          out_addr_d = cur_addr_q;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (cur_addr_q == end_addr_q) begin
            state_d = DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
            state_d    = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == SEND);
  end

  // State, address and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign rf_addr   = cur_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a
// behavioural 8 x 16 register file.
module tb_regfile_dump;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [2:0]  first_addr;
  logic [2:0]  last_addr;
  logic        busy;
  logic        done;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_addr;
  logic [15:0] out_data;

  logic [15:0] rf [8];

  int errors = 0;
  int checks = 0;

  regfile_dump dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  assign rf_data = rf[rf_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] model(
    input logic [2:0] a
  );
    logic [15:0] v;
    v = (a == 3'd0) ? 16'h0001 : 16'h1111 * {13'd0, a};
    return v;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: plain, 1: extra start mid-dump,
  // 2: abort high together with the start
  task automatic dump(
    input logic [2:0] f,
    input logic [2:0] l,
    input int         mode
  );
    int         n;
    int         cyc;
    int         first_v;
    bit         got_done;
    logic [2:0] ea;
    logic [2:0] span;
    int         exp_n;
    n        = 0;
    cyc      = 0;
    first_v  = -1;
    got_done = 1'b0;
    span     = l - f;
    exp_n    = int'(span) + 1;
    first_addr = f;
    last_addr  = l;
    out_ready  = 1'b1;
    start      = 1'b1;
    abort      = (mode == 2);
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("valid_in_read", {31'd0, out_valid}, 0);
    while (!got_done && cyc < 80) begin
      start = (mode == 1) && (cyc == 3);
      if (start) begin
        first_addr = f + 3'd3;
        last_addr  = f + 3'd3;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        ea = f + n[2:0];
        chk("pair_addr", {29'd0, out_addr},
            {29'd0, ea});
        chk("pair_data", {16'd0, out_data},
            {16'd0, model(ea)});
        n++;
      end
      tick();
      cyc++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    chk("pair_count", n, exp_n);
    chk("first_valid_cycle", first_v, 1);
    chk("done_cycle", cyc, 2 * exp_n);
    chk("valid_at_done", {31'd0, out_valid}, 0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("busy_fall", {31'd0, busy}, 0);
    tick();
    chk("no_second_done", {31'd0, done}, 0);
  endtask

  initial begin
    int cyc;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rf[i] = model(3'(i));
    end

    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_rf_addr", {29'd0, rf_addr}, 0);
    chk("rst_out_addr", {29'd0, out_addr}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // full dump and wrapped dump
    dump(3'd0, 3'd7, 0);
    dump(3'd6, 3'd1, 0);

    // single register with backpressure
    first_addr = 3'd3;
    last_addr  = 3'd3;
    out_ready  = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_addr", {29'd0, out_addr}, 3);
      chk("stall_data", {16'd0, out_data}, 16'h3333);
      chk("stall_no_done", {31'd0, done}, 0);
      tick();
    end
    chk("stall_still_valid", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    tick();
    chk("stall_done", {31'd0, done}, 1);
    chk("stall_valid_drop", {31'd0, out_valid}, 0);
    tick();
    chk("stall_idle", {31'd0, busy}, 0);

    // abort during SEND of address 2
    first_addr = 3'd0;
    last_addr  = 3'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!(out_valid && out_addr == 3'd2)
           && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("abort_reached_a2", {31'd0, out_valid}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    tick();
    chk("abort_no_done", {31'd0, done}, 0);
    dump(3'd5, 3'd5, 0);

    // restart ignored, start with abort accepted
    dump(3'd0, 3'd3, 1);
    dump(3'd4, 3'd6, 2);

    // asynchronous reset mid-SEND
    first_addr = 3'd0;
    last_addr  = 3'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_valid", {31'd0, out_valid}, 0);
    chk("arst_rf_addr", {29'd0, rf_addr}, 0);
    chk("arst_out_addr", {29'd0, out_addr}, 0);
    chk("arst_out_data", {16'd0, out_data}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_done", {31'd0, done}, 0);
    dump(3'd0, 3'd0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 8 x 16-bit `register_file`: on a start pulse it walks a programmable address range through one register-file read port and streams each `(address, value)` pair out over a valid/ready handshake. It is the reader counterpart to the register-file write path. It sits beside the core, driving the `rs_addr` port when the core is halted, and feeds a debug UART or trace FIFO.

## Interface
- `DATA_WIDTH`, 16: register width; must match `register_file`.
- `ADDR_WIDTH`, 3: register address width; the file holds 2**ADDR_WIDTH = 8 registers.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; one clock, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a dump; ignored unless idle.
- `abort`  in  1  synchronous cancel of an active dump.
- `first_addr`  in  ADDR_WIDTH  first register to dump; sampled on accepted `start`.
- `last_addr`  in  ADDR_WIDTH  last register to dump; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until return to IDLE.
- `done`  out  1  one-cycle pulse after the last pair is accepted.
- `rf_addr`  out  ADDR_WIDTH  read address; connects to `register_file.rs_addr`.
- `rf_data`  in  DATA_WIDTH  read data from `register_file.rs_data` (combinational read).
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `out_addr`  out  ADDR_WIDTH  address of the presented value.
- `out_data`  out  DATA_WIDTH  captured register value.

## Operation
- States are IDLE, READ, SEND and DONE.
- **IDLE**: if `start` is high, latch `first_addr` into `cur_addr` and `last_addr` into `end_addr`, then go to READ. `rf_addr` holds `cur_addr` in every state.
- **READ**: `rf_addr` = `cur_addr`. At the clock edge, capture `rf_data` into `out_data` and `cur_addr` into `out_addr`, then go to SEND.
- **SEND**: `out_valid` = 1. `out_data` and `out_addr` stay stable until the handshake (`out_valid & out_ready`) completes.
  - On handshake with `cur_addr == end_addr`, go to DONE.
  - On any other handshake, `cur_addr` = `cur_addr + 1` modulo 2**ADDR_WIDTH, then go to READ.
- **DONE**: `done` = 1 for exactly one cycle, then go to IDLE.
- Range handling:
  - When `first_addr > last_addr`, the walk wraps from 7 to 0.
  - Registers dumped = ((last - first) mod 8) + 1.
  - `first == last` dumps exactly one register. The full-file dump is 1..0 or 0..7.
- `abort` is high-priority in READ and SEND. It forces IDLE on the next edge, drops `out_valid` and does not pulse `done`. In IDLE and DONE it has no effect.
- `start` while busy is ignored and not queued. `start` and `abort` high together in IDLE: the start is accepted.
- The dump is not an atomic snapshot. A write to register N that lands before N's READ edge is visible; a later write is not.
- Reset values: state IDLE, and `busy`, `done`, `out_valid`, `rf_addr`, `out_addr`, `out_data` all 0. Asserting reset mid-dump clears immediately, and no `done` follows.

## Timing
- `start` sampled at edge k gives READ in cycle k+1 and `out_valid` in cycle k+2.
- Each register costs 2 cycles minimum (READ + SEND) when `out_ready` is held high.
- A full 8-register dump with `out_ready` always high takes 16 cycles from the first READ to the last handshake. `done` follows in the next cycle and `busy` falls the cycle after `done`.
- Backpressure adds one cycle per stalled SEND cycle. Values do not change while stalled.
- `out_valid` must not depend combinationally on `out_ready`. All outputs are registered except `rf_addr`, which is driven from the `cur_addr` register.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_WIDTH` and `REG_ADDR_WIDTH` constants, shared with `register_file`.
  - A `dump_state_t` enum (IDLE, READ, SEND, DONE).
- No sub-module is needed; the block is a single FSM plus address and data registers.
- Top-level muxing of `rs_addr` between the core and this block lives outside this block.

## Test plan
- Preload r0..r7 = 16'h0001, 16'h1111 … 16'h7777 through `register_file`, then dump 0..7 with `out_ready`=1 → 8 pairs in order (0,0001)…(7,7777). `out_valid` first rises 2 cycles after `start`, and `done` pulses once, 16 cycles after the first READ.
- Wrap dump 6..1 → addresses 6,7,0,1 in that order with matching data; exactly 4 handshakes, then `done`.
- Single-register dump 3..3 with `out_ready` low for 5 cycles → `out_valid` high and (3,3333) stable for those 5 cycles; one handshake, then `done`.
- `abort` asserted during the SEND of address 2 in a 0..7 dump → `out_valid` is 0 next cycle, no `done`, `busy` falls, and a new `start` is accepted afterwards.
- `start` pulsed again mid-dump → ignored: the pair sequence is unchanged and only one `done` occurs.
- `reset_n` asserted asynchronously mid-SEND → all outputs are 0 immediately with no clock edge; after release the block is in IDLE and a fresh dump of 0..0 returns (0,0001).
